// File: rtl/clk_div_multi_pkg.sv
// Shared constants and bus-slicing helper for the multi-channel clock divider.
// Imported by the channel module and by the top level.
package clk_div_multi_pkg;

    localparam int CNT_W_DEF    = 10;
    localparam int NUM_CH_DEF   = 4;
    localparam int RST_DIV_DEF  = 1;
    localparam int RST_HIGH_DEF = 1;

    // Bit offset of channel idx inside a packed per-channel bus.
    function automatic int slice_base(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, double-buffered div/high settings,
// registered duty output and period-start tick, plus the div = 0 bypass mux.
module clk_div_ch
    import clk_div_multi_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RST_DIV  = RST_DIV_DEF,
    parameter int RST_HIGH = RST_HIGH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] high_in,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] act_high;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_high;
    logic             out_q;
    logic             wrap;

    assign wrap = (cnt == act_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            act_div  <= CNT_W'(RST_DIV);
            act_high <= CNT_W'(RST_HIGH);
            sh_div   <= CNT_W'(RST_DIV);
            sh_high  <= CNT_W'(RST_HIGH);
            pending  <= 1'b0;
            out_q    <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (load) begin
                sh_div  <= div_in;
                sh_high <= high_in;
            end

            if (sync) begin
                // Phase restart: behaves like a reset edge that keeps the settings.
                cnt     <= '0;
                out_q   <= 1'b0;
                tick    <= 1'b0;
                pending <= 1'b0;
                if (load) begin
                    act_div  <= div_in;
                    act_high <= high_in;
                end else if (pending) begin
                    act_div  <= sh_div;
                    act_high <= sh_high;
                end
            end else if (en) begin
                cnt   <= wrap ? '0 : cnt + CNT_W'(1);
                out_q <= (cnt < act_high);
                tick  <= (cnt == '0);
                if (wrap) begin
                    // New settings take effect only on a period boundary.
                    pending <= 1'b0;
                    if (load) begin
                        act_div  <= div_in;
                        act_high <= high_in;
                    end else if (pending) begin
                        act_div  <= sh_div;
                        act_high <= sh_high;
                    end
                end else if (load) begin
                    pending <= 1'b1;
                end
            end else begin
                tick <= 1'b0;
                if (load) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    // Glitch exposure at the bypass switch is accepted for this clock tree.
    assign clk_out = (act_div == '0) ? clk : out_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels
// sharing clock, reset, enable and the phase-sync restart.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int RST_DIV  = RST_DIV_DEF,
    parameter int RST_HIGH = RST_HIGH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sync,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] div_n,
    input  logic [NUM_CH*CNT_W-1:0] high_n,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W    (CNT_W),
            .RST_DIV  (RST_DIV),
            .RST_HIGH (RST_HIGH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .sync    (sync),
            .load    (load[i]),
            .div_in  (div_n[slice_base(i, CNT_W) +: CNT_W]),
            .high_in (high_n[slice_base(i, CNT_W) +: CNT_W]),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: reset defaults, shadow load/apply,
// duty extremes, bypass entry/exit, phase sync, enable freeze and async reset.
module tb_clk_div_multi;

    localparam int CW = 10;
    localparam int NC = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           sync = 1'b0;
    logic [NC-1:0]  load = '0;
    logic [NC*CW-1:0] div_n = '0;
    logic [NC*CW-1:0] high_n = '0;
    logic [NC-1:0]  clk_out;
    logic [NC-1:0]  tick;
    logic [NC-1:0]  pending;

    int n_cmp = 0;
    int n_bad = 0;
    int per [NC];
    int hi  [NC];
    logic [NC-1:0] e_out;
    logic [NC-1:0] e_tck;

    clk_div_multi #(.CNT_W(CW), .NUM_CH(NC), .RST_DIV(1), .RST_HIGH(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .load    (load),
        .div_n   (div_n),
        .high_n  (high_n),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; returns on the falling edge, where outputs are sampled
    // and the next inputs are driven.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input int d, input int h);
        div_n[ch*CW +: CW]  = CW'(d);
        high_n[ch*CW +: CW] = CW'(h);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (clk_out !== 4'h0) begin n_bad++; $display("FAIL rst_clk_out got %b want 0000", clk_out); end
        n_cmp++; if (tick !== 4'h0) begin n_bad++; $display("FAIL rst_tick got %b want 0000", tick); end
        n_cmp++; if (pending !== 4'h0) begin n_bad++; $display("FAIL rst_pending got %b want 0000", pending); end
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            e_out = (k % 2 == 1) ? 4'hF : 4'h0;
            n_cmp++; if (clk_out !== e_out) begin n_bad++; $display("FAIL dflt_clk_out k=%0d got %b want %b", k, clk_out, e_out); end
            n_cmp++; if (tick !== e_out) begin n_bad++; $display("FAIL dflt_tick k=%0d got %b want %b", k, tick, e_out); end
            n_cmp++; if (pending !== 4'h0) begin n_bad++; $display("FAIL dflt_pending k=%0d got %b want 0000", k, pending); end
        end
    endtask

    task automatic test_load_ch0();
        set_ch(0, 4, 2);
        load = 4'b0001;
        cyc();
        load = 4'b0000;
        n_cmp++; if (pending !== 4'b0001) begin n_bad++; $display("FAIL ld_pending_set got %b want 0001", pending); end
        n_cmp++; if (clk_out !== 4'hF) begin n_bad++; $display("FAIL ld_old_period got %b want 1111", clk_out); end
        cyc();
        n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL ld_pending_clr got %b want 0000", pending); end
        n_cmp++; if (clk_out !== 4'h0) begin n_bad++; $display("FAIL ld_wrap_out got %b want 0000", clk_out); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            e_out = (i % 2 == 0) ? 4'hE : 4'h0;
            e_tck = e_out;
            e_out[0] = ((i % 5) < 2);
            e_tck[0] = ((i % 5) == 0);
            n_cmp++; if (clk_out !== e_out) begin n_bad++; $display("FAIL ld_clk_out i=%0d got %b want %b", i, clk_out, e_out); end
            n_cmp++; if (tick !== e_tck) begin n_bad++; $display("FAIL ld_tick i=%0d got %b want %b", i, tick, e_tck); end
        end
    endtask

    task automatic test_duty_extremes();
        set_ch(0, 4, 0);
        load = 4'b0001;
        sync = 1'b1;
        cyc();
        load = 4'b0000;
        sync = 1'b0;
        n_cmp++; if (pending !== 4'h0) begin n_bad++; $display("FAIL h0_pending got %b want 0000", pending); end
        n_cmp++; if (tick !== 4'h0) begin n_bad++; $display("FAIL h0_sync_tick got %b want 0000", tick); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_cmp++; if (clk_out[0] !== 1'b0) begin n_bad++; $display("FAIL h0_out i=%0d got %b want 0", i, clk_out[0]); end
            n_cmp++; if (tick[0] !== ((i % 5) == 0)) begin n_bad++; $display("FAIL h0_tick i=%0d got %b want %b", i, tick[0], ((i % 5) == 0)); end
        end
        set_ch(0, 4, 9);
        load = 4'b0001;
        sync = 1'b1;
        cyc();
        load = 4'b0000;
        sync = 1'b0;
        n_cmp++; if (clk_out[0] !== 1'b0) begin n_bad++; $display("FAIL h9_sync_out got %b want 0", clk_out[0]); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_cmp++; if (clk_out[0] !== 1'b1) begin n_bad++; $display("FAIL h9_out i=%0d got %b want 1", i, clk_out[0]); end
            n_cmp++; if (tick[0] !== ((i % 5) == 0)) begin n_bad++; $display("FAIL h9_tick i=%0d got %b want %b", i, tick[0], ((i % 5) == 0)); end
        end
    endtask

    task automatic test_bypass();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        set_ch(2, 0, 1);
        load = 4'b0100;
        cyc();
        load = 4'b0000;
        n_cmp++; if (pending[2] !== 1'b1) begin n_bad++; $display("FAIL byp_pending_set got %b want 1", pending[2]); end
        cyc();
        n_cmp++; if (pending[2] !== 1'b0) begin n_bad++; $display("FAIL byp_pending_clr got %b want 0", pending[2]); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (clk_out[2] !== 1'b1) begin n_bad++; $display("FAIL byp_high i=%0d got %b want 1", i, clk_out[2]); end
            @(negedge clk);
            n_cmp++; if (clk_out[2] !== 1'b0) begin n_bad++; $display("FAIL byp_low i=%0d got %b want 0", i, clk_out[2]); end
            n_cmp++; if (tick[2] !== 1'b1) begin n_bad++; $display("FAIL byp_tick i=%0d got %b want 1", i, tick[2]); end
        end
        set_ch(2, 2, 1);
        load = 4'b0100;
        cyc();
        load = 4'b0000;
        n_cmp++; if (clk_out[2] !== 1'b1) begin n_bad++; $display("FAIL byp_exit_out got %b want 1", clk_out[2]); end
        n_cmp++; if (tick[2] !== 1'b1) begin n_bad++; $display("FAIL byp_exit_tick got %b want 1", tick[2]); end
        n_cmp++; if (pending[2] !== 1'b0) begin n_bad++; $display("FAIL byp_exit_pending got %b want 0", pending[2]); end
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_cmp++; if (clk_out[2] !== ((i % 3) == 0)) begin n_bad++; $display("FAIL byp_p3_out i=%0d got %b want %b", i, clk_out[2], ((i % 3) == 0)); end
            n_cmp++; if (tick[2] !== ((i % 3) == 0)) begin n_bad++; $display("FAIL byp_p3_tick i=%0d got %b want %b", i, tick[2], ((i % 3) == 0)); end
        end
    endtask

    task automatic test_sync();
        set_ch(0, 2, 1);
        set_ch(1, 4, 2);
        set_ch(2, 6, 3);
        set_ch(3, 9, 4);
        per = '{3, 5, 7, 10};
        hi  = '{1, 2, 3, 4};
        load = 4'hF;
        cyc();
        load = 4'h0;
        repeat (12) cyc();
        n_cmp++; if (pending !== 4'h0) begin n_bad++; $display("FAIL sync_pre_pending got %b want 0000", pending); end
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        n_cmp++; if (clk_out !== 4'h0) begin n_bad++; $display("FAIL sync_out got %b want 0000", clk_out); end
        n_cmp++; if (tick !== 4'h0) begin n_bad++; $display("FAIL sync_tick got %b want 0000", tick); end
        for (int k = 0; k < 30; k++) begin
            cyc();
            for (int c = 0; c < NC; c++) begin
                e_out[c] = ((k % per[c]) < hi[c]);
                e_tck[c] = ((k % per[c]) == 0);
            end
            n_cmp++; if (clk_out !== e_out) begin n_bad++; $display("FAIL sync_run_out k=%0d got %b want %b", k, clk_out, e_out); end
            n_cmp++; if (tick !== e_tck) begin n_bad++; $display("FAIL sync_run_tick k=%0d got %b want %b", k, tick, e_tck); end
        end
        set_ch(3, 3, 2);
        per[3] = 4;
        hi[3]  = 2;
        load = 4'b1000;
        sync = 1'b1;
        cyc();
        load = 4'b0000;
        sync = 1'b0;
        n_cmp++; if (pending !== 4'h0) begin n_bad++; $display("FAIL synld_pending got %b want 0000", pending); end
        n_cmp++; if (clk_out !== 4'h0) begin n_bad++; $display("FAIL synld_out got %b want 0000", clk_out); end
        for (int k = 0; k < 8; k++) begin
            cyc();
            for (int c = 0; c < NC; c++) begin
                e_out[c] = ((k % per[c]) < hi[c]);
                e_tck[c] = ((k % per[c]) == 0);
            end
            n_cmp++; if (clk_out !== e_out) begin n_bad++; $display("FAIL synld_run_out k=%0d got %b want %b", k, clk_out, e_out); end
            n_cmp++; if (tick !== e_tck) begin n_bad++; $display("FAIL synld_run_tick k=%0d got %b want %b", k, tick, e_tck); end
        end
    endtask

    task automatic test_enable();
        int k;
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
        cyc();
        en = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin
                set_ch(1, 2, 2);
                load = 4'b0010;
            end else begin
                load = 4'b0000;
            end
            cyc();
            n_cmp++; if (clk_out !== 4'b1110) begin n_bad++; $display("FAIL en0_out c=%0d got %b want 1110", c, clk_out); end
            n_cmp++; if (tick !== 4'h0) begin n_bad++; $display("FAIL en0_tick c=%0d got %b want 0000", c, tick); end
            if (c >= 2) begin
                n_cmp++; if (pending !== 4'b0010) begin n_bad++; $display("FAIL en0_pending c=%0d got %b want 0010", c, pending); end
            end
        end
        load = 4'b0000;
        en = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            cyc();
            k = r + 1;
            for (int c = 0; c < NC; c++) begin
                e_out[c] = ((k % per[c]) < hi[c]);
                e_tck[c] = ((k % per[c]) == 0);
            end
            if (r <= 3) begin
                e_out[1] = 1'b0;
                e_tck[1] = 1'b0;
            end else begin
                e_out[1] = (((r - 4) % 3) < 2);
                e_tck[1] = (((r - 4) % 3) == 0);
            end
            n_cmp++; if (clk_out !== e_out) begin n_bad++; $display("FAIL en1_out r=%0d got %b want %b", r, clk_out, e_out); end
            n_cmp++; if (tick !== e_tck) begin n_bad++; $display("FAIL en1_tick r=%0d got %b want %b", r, tick, e_tck); end
            if (r == 2) begin
                n_cmp++; if (pending !== 4'b0010) begin n_bad++; $display("FAIL en1_pending_hold got %b want 0010", pending); end
            end
            if (r == 3) begin
                n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL en1_pending_clr got %b want 0000", pending); end
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (clk_out !== 4'h0) begin n_bad++; $display("FAIL arst_out got %b want 0000", clk_out); end
        n_cmp++; if (tick !== 4'h0) begin n_bad++; $display("FAIL arst_tick got %b want 0000", tick); end
        n_cmp++; if (pending !== 4'h0) begin n_bad++; $display("FAIL arst_pending got %b want 0000", pending); end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        cyc();
        n_cmp++; if (clk_out !== 4'hF) begin n_bad++; $display("FAIL arst_dflt1 got %b want 1111", clk_out); end
        cyc();
        n_cmp++; if (clk_out !== 4'h0) begin n_bad++; $display("FAIL arst_dflt2 got %b want 0000", clk_out); end
    endtask

    initial begin
        test_reset();
        test_load_ch0();
        test_duty_extremes();
        test_bypass();
        test_sync();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parameterised, multi-channel programmable clock divider for the DDS clocking tree; successor to the single fixed-duty divider.
- Each channel has its own runtime divide ratio and high-time (duty) setting, double-buffered so updates land only on a period boundary.
- Adds enable, a cross-channel phase-sync restart, a per-channel period-start tick strobe and an update-pending status.
- Bypass (div = 0) passes the source clock straight through, as before.

Parameters:
- CNT_W, 10, width of the divide and high-time fields and of the per-channel counter.
- NUM_CH, 4, number of independent output channels.
- RST_DIV, 1, active divide value loaded at reset; period = RST_DIV+1 cycles.
- RST_HIGH, 1, active high-time loaded at reset, in source cycles.

Ports:
- clk  in  1  source clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global count enable; low freezes all counters and outputs.
- sync  in  1  one-cycle strobe; restarts all channel counters phase-aligned.
- load  in  NUM_CH  per-channel strobe; captures that channel's div_n/high_n slice into its shadow register.
- div_n  in  NUM_CH*CNT_W  per-channel divide value; slice i = [i*CNT_W +: CNT_W]; period = div_n+1 cycles; 0 = bypass.
- high_n  in  NUM_CH*CNT_W  per-channel high-time in source cycles, same slicing.
- clk_out  out  NUM_CH  divided clock per channel.
- tick  out  NUM_CH  one-cycle pulse, registered, marking the period start.
- pending  out  NUM_CH  shadow holds a value not yet applied.

Behaviour:
- Reset (async, rst=1):
  - cnt = 0, act_div = RST_DIV, act_high = RST_HIGH.
  - shadow registers = RST_DIV / RST_HIGH, pending = 0.
  - out_q = 0, tick = 0.
  - Deassertion takes effect on the next rising edge of clk.
- Per channel i, per clk edge, with en = 1:
  - If cnt == act_div then cnt <= 0 (wrap); otherwise cnt <= cnt+1.
  - out_q <= (cnt < act_high), evaluated on the pre-update cnt, so out_q lags cnt by one cycle.
  - tick <= (cnt == 0).
  - High-time rules: act_high = 0 gives constant low; act_high > act_div gives constant high; no overflow handling is needed (unsigned compare).
  - Example: act_div = 3, act_high = 2 gives a period of 4 cycles with pattern 1,1,0,0.
- en = 0:
  - cnt, out_q and shadows hold; tick = 0.
  - load still captures into the shadow; apply is deferred until en = 1.
- load[i] = 1:
  - shadow_i <= slice i of div_n/high_n; pending[i] <= 1.
  - A later load before apply overwrites the shadow (last write wins).
- Apply:
  - In any enabled wrap cycle (cnt == act_div) with pending = 1, act_* <= shadow and pending <= 0; the new period starts at cnt = 0.
  - If load and the wrap coincide, the newly presented slice is applied directly in that cycle and pending stays 0.
- sync = 1, regardless of en:
  - All channels: cnt <= 0, out_q <= 0, tick <= 0.
  - Any pending shadow is applied immediately and pending <= 0.
  - load in the same cycle is applied directly.
  - The following enabled cycles match post-reset timing, so all channels are phase-aligned.
- Bypass (act_div = 0):
  - clk_out[i] = clk, a combinational mux after out_q; tick[i] = 1 while en = 1.
  - Every enabled cycle is a wrap, so a pending non-zero value leaves bypass at the next enabled edge.
  - The glitch exposure is only at the bypass mux switch and is accepted.
- Otherwise clk_out[i] = out_q[i].
- Channels are fully independent except for the shared en, sync, rst and clk.

Decomposition:
- Shared package holds:
  - the CNT_W default and the slice-index helper (base offset = i*CNT_W);
  - reset constants RST_DIV_DEF and RST_HIGH_DEF.
- One sub-module, clk_div_ch: a single channel holding counter, shadow, pending, apply logic, out_q, tick and the bypass mux.
- The top generate-loops NUM_CH instances and slices the buses; no other logic at the top level.

Test Plan:
- Reset release, defaults RST_DIV = 1, RST_HIGH = 1, en = 1 -> every channel's clk_out toggles 0,1,0,1 with period 2 (one high, one low); tick fires every 2 cycles; pending = 0.
- ch0 load div = 4, high = 2 mid-period -> pending[0] = 1 until the current period ends, then a 5-cycle period with pattern 1,1,0,0,0; pending[0] drops at the wrap; ch1..3 unchanged.
- Load with high = 0, then with high = 9 at div = 4 -> constant 0, then constant 1; tick still every 5 cycles.
- ch2 load div = 0 -> after the wrap clk_out[2] follows clk and tick[2] is held at 1. Then load div = 2, high = 1 -> the next edge exits bypass into period 3 with pattern 1,0,0.
- Channels set to div = 2, 4, 6, 9, run unaligned, then pulse sync -> all ticks fire in the same cycle, then each every 3, 5, 7 and 10 cycles. Also pulse sync together with a load on ch3 -> ch3 starts its new value immediately.
- en low for 7 cycles mid-period with a load during the low window -> outputs and counters frozen, tick = 0, pending = 1. After en returns, the period resumes at the frozen count and the new value applies at the wrap. Asserting rst mid-period -> outputs go to 0 immediately.
